// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory master: state encoding,
// default bus widths and the wait-counter width.
package lc3_mem_pkg;

  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;
  localparam int LC3_WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } mem_state_e;

endpackage

// File: rtl/lc3_mem_master_if.sv
// Request handshake from the control FSM plus the single-port RAM bus.
// The master modport is the memory master's view; slave is its surroundings.
interface lc3_mem_master_if import lc3_mem_pkg::*; #(
  parameter int ADDR_SIZE = LC3_ADDR_W,
  parameter int DATA_SIZE = LC3_DATA_W
);
  logic                 req;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0] req_wdata;
  logic                 busy;
  logic                 done;
  logic [DATA_SIZE-1:0] rdata;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [DATA_SIZE-1:0] ram_din;
  logic [DATA_SIZE-1:0] ram_dout;

  modport master (
    input  req, req_we, req_addr, req_wdata, ram_dout,
    output busy, done, rdata, ram_we, ram_addr, ram_din
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, ram_dout,
    input  busy, done, rdata, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/lc3_sat_cnt.sv
// 16-bit event counter that sticks at all-ones; cleared only by rst_n.
module lc3_sat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);
  logic [15:0] cnt_r;

  // count register, saturating at 16'hFFFF
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'h0000;
    end else if (inc && (cnt_r != 16'hFFFF)) begin
      cnt_r <= cnt_r + 16'h0001;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign count = cnt_r;
endmodule

// File: rtl/lc3_mem_master.sv
// LC-3 memory master: owns MAR/MDR and sequences setup/write-pulse/hold/read.
// Optional access counters enabled by defining LC3_MEM_PERF_CNT_EN.
module lc3_mem_master import lc3_mem_pkg::*; #(
  parameter int ADDR_SIZE   = LC3_ADDR_W,
  parameter int DATA_SIZE   = LC3_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  lc3_mem_master_if.master bus,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count
);
  localparam logic [LC3_WAIT_W-1:0] WAIT_LOAD = LC3_WAIT_W'(WAIT_CYCLES - 1);

  generate
    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
      $error("lc3_mem_master: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  mem_state_e           state_r, state_s;
  logic [LC3_WAIT_W-1:0] cnt_r, cnt_s;
  logic [ADDR_SIZE-1:0] mar_r, mar_s;
  logic [DATA_SIZE-1:0] mdr_r, mdr_s;
  logic                 we_r, we_s;
  logic                 ram_we_r, busy_r, done_r;

  // next-state and MAR/MDR/counter update
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mar_s   = mar_r;
    mdr_s   = mdr_r;
    we_s    = we_r;
    case (state_r)
      IDLE: begin
        if (bus.req) begin
          state_s = SETUP;
          mar_s   = bus.req_addr;
          we_s    = bus.req_we;
          if (bus.req_we) begin
            mdr_s = bus.req_wdata;
          end else begin
            mdr_s = mdr_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        cnt_s = WAIT_LOAD;
        if (we_r) begin
          state_s = WRITE;
        end else begin
          state_s = READ;
        end
      end
      WRITE: begin
        if (cnt_r == {LC3_WAIT_W{1'b0}}) begin
          state_s = HOLD;
        end else begin
          cnt_s = cnt_r - LC3_WAIT_W'(1);
        end
      end
      HOLD: state_s = DONE;
      READ: begin
        // RAM output has had WAIT_CYCLES cycles to settle at this point
        if (cnt_r == {LC3_WAIT_W{1'b0}}) begin
          mdr_s   = bus.ram_dout;
          state_s = DONE;
        end else begin
          cnt_s = cnt_r - LC3_WAIT_W'(1);
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state, datapath and output registers; outputs decode the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {LC3_WAIT_W{1'b0}};
      mar_r    <= {ADDR_SIZE{1'b0}};
      mdr_r    <= {DATA_SIZE{1'b0}};
      we_r     <= 1'b0;
      ram_we_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      mar_r    <= mar_s;
      mdr_r    <= mdr_s;
      we_r     <= we_s;
      ram_we_r <= (state_s == WRITE);
      busy_r   <= (state_s != IDLE);
      done_r   <= (state_s == DONE);
    end
  end

  assign bus.ram_we   = ram_we_r;
  assign bus.ram_addr = mar_r;
  assign bus.ram_din  = mdr_r;
  assign bus.rdata    = mdr_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

`ifdef LC3_MEM_PERF_CNT_EN
  logic rd_inc_s, wr_inc_s;

  assign rd_inc_s = (state_r == DONE) && !we_r;
  assign wr_inc_s = (state_r == DONE) &&  we_r;

  lc3_sat_cnt u_rd_cnt (.clk(clk), .rst_n(rst_n), .inc(rd_inc_s), .count(rd_count));
  lc3_sat_cnt u_wr_cnt (.clk(clk), .rst_n(rst_n), .inc(wr_inc_s), .count(wr_count));
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif
endmodule

// File: tb/tb_lc3_mem_master.sv
// Directed bench for lc3_mem_master: three instances with WAIT_CYCLES 1, 2, 3,
// each attached to its own small RAM model and bus monitor.
module tb_lc3_mem_master;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic        req       [3];
  logic        req_we    [3];
  logic [15:0] req_addr  [3];
  logic [15:0] req_wdata [3];

  logic [2:0]  obs_busy, obs_done, obs_we;
  logic [15:0] obs_rdata [3];
  logic [15:0] obs_addr  [3];
  logic [15:0] rd_cnt    [3];
  logic [15:0] wr_cnt    [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    lc3_mem_master_if #(.ADDR_SIZE(16), .DATA_SIZE(16)) bus ();
    logic [15:0] mem [0:1023];
    bit          wr  [0:1023];
    bit          prev_we;
    logic [15:0] prev_addr, prev_din;
    int          we_cyc   = 0;
    int          done_cnt = 0;
    int          hit20    = 0;
    int          stab_err = 0;

    assign bus.req       = req[g];
    assign bus.req_we    = req_we[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.ram_dout  = wr[bus.ram_addr[9:0]] ? mem[bus.ram_addr[9:0]]
                         : ((bus.ram_addr == 16'h0008) ? 16'h1222 : 16'h0000);
    assign obs_busy[g]   = bus.busy;
    assign obs_done[g]   = bus.done;
    assign obs_we[g]     = bus.ram_we;
    assign obs_rdata[g]  = bus.rdata;
    assign obs_addr[g]   = bus.ram_addr;

    lc3_mem_master #(.ADDR_SIZE(16), .DATA_SIZE(16), .WAIT_CYCLES(g + 1)) dut (
      .clk(clk), .rst_n(rst_n[g]), .bus(bus.master),
      .rd_count(rd_cnt[g]), .wr_count(wr_cnt[g])
    );

    // RAM write and bus monitor: pulse width, setup/hold stability, stray accesses
    always @(posedge clk) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr[9:0]] <= bus.ram_din;
        wr[bus.ram_addr[9:0]]  <= 1'b1;
        we_cyc <= we_cyc + 1;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.ram_addr == 16'h0020) hit20 <= hit20 + 1;
      if ((bus.ram_we || prev_we) &&
          ((bus.ram_addr != prev_addr) || (bus.ram_din != prev_din)))
        stab_err <= stab_err + 1;
      prev_we   <= bus.ram_we;
      prev_addr <= bus.ram_addr;
      prev_din  <= bus.ram_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one complete access; lat counts cycles from the accepting edge to done
  task automatic access(input int i, input logic we, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] rd);
    req[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = d;
    step();
    req[i] = 1'b0;
    lat = 1;
    while (!obs_done[i] && lat < 40) begin
      step();
      lat++;
    end
    rd = obs_rdata[i];
    step();
  endtask

  initial begin
    int          lat, snap_a, snap_b, n;
    int          t [3];
    logic [15:0] rd;
    logic [15:0] b2b_addr [3];
    logic [15:0] b2b_data [3];
    b2b_addr = '{16'h0100, 16'h0101, 16'h0102};
    b2b_data = '{16'hA100, 16'hB201, 16'hC302};

    rst_n = 3'b000;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 16'h0000; req_wdata[i] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 3'b111;
    step();

    check("rst_busy",  {29'd0, obs_busy}, 32'd0);
    check("rst_done",  {29'd0, obs_done}, 32'd0);
    check("rst_we",    {29'd0, obs_we},   32'd0);
    check("rst_addr",  obs_addr[0],  16'h0000);
    check("rst_rdata", obs_rdata[0], 16'h0000);

    // write then read back, WAIT_CYCLES=1
    snap_a = g_inst[0].we_cyc;
    access(0, 1'b1, 16'h000F, 16'h0007, lat, rd);
    check("wr_lat",    lat, 4);
    check("wr_mdr",    rd, 16'h0007);
    check("we_width",  g_inst[0].we_cyc - snap_a, 1);
    check("ram_f",     g_inst[0].mem[15], 16'h0007);
    check("busy_idle", obs_busy[0], 1'b0);
    access(0, 1'b0, 16'h000F, 16'h0000, lat, rd);
    check("rd_lat",    lat, 3);
    check("rd_data",   rd, 16'h0007);

    // read of an unwritten location
    snap_a = g_inst[0].we_cyc;
    access(0, 1'b0, 16'h0008, 16'h0000, lat, rd);
    check("rd8_lat",   lat, 3);
    check("rd8_data",  rd, 16'h1222);
    check("rd8_no_we", g_inst[0].we_cyc - snap_a, 0);
    check("rd8_hold",  obs_rdata[0], 16'h1222);

    // request pulsed while a write is in flight must be dropped
    snap_a = g_inst[0].done_cnt;
    snap_b = g_inst[0].hit20;
    req[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0010; req_wdata[0] = 16'h4444;
    step();
    req[0] = 1'b0;
    step();
    step();
    check("busy_mid", obs_busy[0], 1'b1);
    req[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0020;
    step();
    req[0] = 1'b0;
    repeat (12) step();
    check("ign_done",  g_inst[0].done_cnt - snap_a, 1);
    check("ign_hit20", g_inst[0].hit20 - snap_b, 0);
    check("ign_ram",   g_inst[0].mem[16], 16'h4444);
    check("stab0",     g_inst[0].stab_err, 0);

    // back-to-back writes with req held high, WAIT_CYCLES=2
    req[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = b2b_addr[0]; req_wdata[1] = b2b_data[0];
    n = 0;
    for (int c = 1; c <= 40 && n < 3; c++) begin
      step();
      if (obs_done[1]) begin
        t[n] = c;
        n++;
        if (n < 3) begin
          req_addr[1] = b2b_addr[n]; req_wdata[1] = b2b_data[n];
        end else begin
          req[1] = 1'b0;
        end
      end
    end
    req[1] = 1'b0;
    check("b2b_n", n, 3);
    if (n == 3) begin
      check("b2b_t0",  t[0], 5);
      check("b2b_gap1", t[1] - t[0], 6);
      check("b2b_gap2", t[2] - t[1], 6);
    end
    step();
    check("b2b_m0", g_inst[1].mem[256], 16'hA100);
    check("b2b_m1", g_inst[1].mem[257], 16'hB201);
    check("b2b_m2", g_inst[1].mem[258], 16'hC302);
    check("stab1",  g_inst[1].stab_err, 0);

    // five reads back through the WAIT_CYCLES=2 instance
    for (int k = 0; k < 5; k++) begin
      access(1, 1'b0, b2b_addr[k % 3], 16'h0000, lat, rd);
      check("b2b_rd_lat",  lat, 4);
      check("b2b_rd_data", rd, b2b_data[k % 3]);
    end

`ifdef LC3_MEM_PERF_CNT_EN
    check("perf_rd", rd_cnt[1], 16'd5);
    check("perf_wr", wr_cnt[1], 16'd3);
    @(negedge clk);
    force g_inst[1].dut.u_rd_cnt.cnt_r = 16'hFFFE;
    step();
    release g_inst[1].dut.u_rd_cnt.cnt_r;
    for (int k = 0; k < 3; k++) access(1, 1'b0, 16'h0100, 16'h0000, lat, rd);
    check("perf_sat", rd_cnt[1], 16'hFFFF);
    check("perf_wr2", wr_cnt[1], 16'd3);
`else
    check("perf_rd_off", rd_cnt[1], 16'd0);
    check("perf_wr_off", wr_cnt[1], 16'd0);
`endif

    // reset during the write pulse, WAIT_CYCLES=3
    snap_a = g_inst[2].done_cnt;
    req[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 16'h0033; req_wdata[2] = 16'h5555;
    step();
    req[2] = 1'b0;
    n = 0;
    while (!obs_we[2] && n < 20) begin
      step();
      n++;
    end
    check("abort_we_seen", obs_we[2], 1'b1);
    step();
    #2;
    rst_n[2] = 1'b0;
    #1;
    check("abort_we",   obs_we[2],   1'b0);
    check("abort_busy", obs_busy[2], 1'b0);
    check("abort_addr", obs_addr[2], 16'h0000);
    check("abort_done", obs_done[2], 1'b0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (10) step();
    check("abort_no_done", g_inst[2].done_cnt - snap_a, 0);
    check("abort_idle",    obs_busy[2], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
